// File: rtl/fpga_ps_pkg.sv
// fpga_ps_pkg: shared state encoding and error codes for the passive-serial loader
package fpga_ps_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_NCFG, S_WSTAT, S_LOAD, S_SHIFT, S_CHK, S_ICLK, S_WINIT, S_DONE, S_ERR
    } state_t;
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_STAT_TMO = 3'd1;
    localparam logic [2:0] ERR_STAT_LOW = 3'd2;
    localparam logic [2:0] ERR_NO_CDONE = 3'd3;
    localparam logic [2:0] ERR_INIT_TMO = 3'd4;
endpackage

// File: rtl/fpga_ps_loader_sync2.sv
// sync2: two-flop synchroniser for an asynchronous level input
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule

// File: rtl/fpga_ps_loader.sv
// fpga_ps_loader: sequences ACEX1K passive-serial configuration from a byte stream
module fpga_ps_loader
    import fpga_ps_pkg::*;
#(
    parameter int NCFG_CYC  = 16,
    parameter int DCLK_DIV  = 2,
    parameter int TMO_CYC   = 4096,
    parameter int INIT_CLKS = 10
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       config_n,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    output logic       dclk,
    output logic       data0,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] err_code,
    output logic       warmres_req
);
    localparam int CW = $clog2(TMO_CYC + 1);
    localparam int DW = $clog2(DCLK_DIV + 1);
    localparam logic [CW-1:0] NCFG_LAST = CW'(NCFG_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] TMO_MAX   = CW'(TMO_CYC);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DCLK_DIV - 1);
    localparam logic [7:0]    INIT_LAST = 8'(INIT_CLKS - 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_div;
    logic          r_hi, r_last, r_warm;
    logic [7:0]    r_bit, r_sh;
    logic [2:0]    r_code, w_code;
    logic          w_stat, w_cdone, w_init, w_tick, w_bitend, w_chk, w_idle, w_acc;

    sync2 #(.RST_VAL(1'b1)) u_sync_stat  (.i_clk(clkin), .i_rst(rst), .i_d(status_n),  .o_q(w_stat));
    sync2 #(.RST_VAL(1'b0)) u_sync_cdone (.i_clk(clkin), .i_rst(rst), .i_d(conf_done), .o_q(w_cdone));
    sync2 #(.RST_VAL(1'b0)) u_sync_init  (.i_clk(clkin), .i_rst(rst), .i_d(init_done), .o_q(w_init));

    assign w_idle      = r_state inside {S_IDLE, S_DONE, S_ERR};
    assign w_chk       = r_state inside {S_LOAD, S_SHIFT, S_CHK, S_ICLK};
    assign w_tick      = r_div == DIV_LAST;
    assign w_bitend    = w_tick && r_hi;
    assign din_ready   = r_state == S_LOAD && w_stat && !abort;
    assign w_acc       = din_valid && din_ready;
    assign config_n    = r_state != S_NCFG;
    // a falling nSTATUS kills the DCLK high phase in the very cycle it is seen
    assign dclk        = (r_state == S_SHIFT || r_state == S_ICLK) && r_hi && w_stat;
    assign data0       = r_state == S_SHIFT && r_sh[0];
    assign busy        = !w_idle;
    assign done        = r_state == S_DONE;
    assign err         = r_state == S_ERR;
    assign err_code    = r_code;
    assign warmres_req = r_warm;

    always_comb begin
        w_next = r_state;
        w_code = r_code;
        if (abort)
            w_next = S_IDLE;
        else if (w_chk && !w_stat) begin
            w_next = S_ERR;
            w_code = ERR_STAT_LOW;
        end else
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (start) begin
                    w_next = S_NCFG;
                    w_code = ERR_NONE;
                end
                S_NCFG:  w_next = r_cnt == NCFG_LAST ? S_WSTAT : S_NCFG;
                S_WSTAT: if (w_stat)
                    w_next = S_LOAD;
                else if (r_cnt == TMO_LAST) begin
                    w_next = S_ERR;
                    w_code = ERR_STAT_TMO;
                end
                S_LOAD:  w_next = w_acc ? S_SHIFT : S_LOAD;
                S_SHIFT: if (w_bitend && r_bit == 8'd7)
                    w_next = r_last ? S_CHK : S_LOAD;
                S_CHK:   if (r_cnt == CW'(1)) begin
                    w_next = w_cdone ? S_ICLK : S_ERR;
                    w_code = w_cdone ? r_code : ERR_NO_CDONE;
                end
                S_ICLK:  w_next = w_bitend && r_bit == INIT_LAST ? S_WINIT : S_ICLK;
                S_WINIT: if (w_init)
                    w_next = S_DONE;
                else if (r_cnt == TMO_LAST) begin
                    w_next = S_ERR;
                    w_code = ERR_INIT_TMO;
                end
                default: w_next = S_IDLE;
            endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_hi    <= 1'b0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_last  <= 1'b0;
            r_code  <= ERR_NONE;
            r_warm  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_code  <= w_code;
            r_warm  <= w_next == S_DONE && r_state != S_DONE;
            r_cnt   <= w_next != r_state ? '0 : r_cnt == TMO_MAX ? r_cnt : r_cnt + 1'b1;
            if (w_acc) begin
                r_sh   <= din;
                r_last <= din_last;
            end else if (r_state == S_SHIFT && w_bitend)
                r_sh <= r_sh >> 1;
            if (w_next != r_state) begin
                r_div <= '0;
                r_hi  <= 1'b0;
                r_bit <= '0;
            end else if (r_state == S_SHIFT || r_state == S_ICLK) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick)
                    r_hi <= !r_hi;
                if (w_bitend)
                    r_bit <= r_bit + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fpga_ps_loader.sv
// tb_fpga_ps_loader: scoreboard bench for the passive-serial loader
module tb_fpga_ps_loader;
    logic clkin = 0, rst = 1, start = 0, abort = 0, din_valid = 0, din_last = 0;
    logic status_n = 1, conf_done = 0, init_done = 0;
    logic [7:0] din = 0;
    logic din_ready, config_n, dclk, data0, busy, done, err, warmres_req;
    logic [2:0] err_code;
    int vectors = 0, miscompares = 0, rise_cnt = 0, warm_cnt = 0;
    bit exp_bits[$];
    logic [3:0] exp_evt[$];
    logic prev_dclk = 0, prev_term = 0;

    always #5 clkin = ~clkin;

    fpga_ps_loader dut (
        .clkin(clkin), .rst(rst), .start(start), .abort(abort), .din(din),
        .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .config_n(config_n), .status_n(status_n), .conf_done(conf_done),
        .init_done(init_done), .dclk(dclk), .data0(data0), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .warmres_req(warmres_req)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clkin) begin
        if (!rst) begin
            if (dclk && !prev_dclk) begin
                rise_cnt++;
                if (exp_bits.size() == 0) fail("unexpected dclk rise");
                else chk("data0 at dclk rise", data0, exp_bits.pop_front());
            end
            if ((done || err) && !prev_term) begin
                if (exp_evt.size() == 0) fail("unexpected done/err");
                else chk("{done,err_code}", {done, err_code}, exp_evt.pop_front());
            end
            if (warmres_req) warm_cnt++;
        end
        prev_dclk = dclk;
        prev_term = done || err;
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic push_seq(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(seq[7-i]);
    endtask

    task automatic wait_ncfg(output int low);
        low = 0;
        while (!config_n && low < 1000) begin tick(); low++; end
    endtask

    task automatic accept(input logic [7:0] b, input bit last);
        int w = 0;
        din = b;
        din_last = last;
        din_valid = 1;
        while (!din_ready && w < 200) begin tick(); w++; end
        if (w >= 200) fail("din_ready never rose");
        tick();
        din_valid = 0;
        din_last = 0;
    endtask

    task automatic shift_len(output int n);
        n = 0;
        while (!din_ready && n < 200) begin tick(); n++; end
    endtask

    task automatic wait_err(input int lim, output int n);
        n = 0;
        while (!err && n < lim) begin tick(); n++; end
    endtask

    task automatic boot_to_load();
        int n;
        status_n = 0;
        pulse_start();
        wait_ncfg(n);
        repeat (5) tick();
        status_n = 1;
    endtask

    initial begin
        int n, base, wc;
        repeat (3) tick();
        chk("reset config_n", config_n, 1);
        chk("reset dclk", dclk, 0);
        chk("reset data0", data0, 0);
        chk("reset din_ready", din_ready, 0);
        chk("reset busy/done/err", {busy, done, err}, 0);
        chk("reset err_code", err_code, 0);
        chk("reset warmres_req", warmres_req, 0);
        rst = 0;
        tick();

        // nominal load of A5, 3C, FF(last)
        status_n = 0;
        base = rise_cnt;
        pulse_start();
        wait_ncfg(n);
        chk("nCONFIG low cycles", n, 16);
        tick();
        pulse_start();
        chk("start while busy config_n", config_n, 1);
        chk("start while busy busy", busy, 1);
        repeat (3) tick();
        status_n = 1;
        conf_done = 1;
        push_seq(8'hA5, 8);
        accept(8'hA5, 0);
        shift_len(n);
        chk("byte A5 shift cycles", n, 32);
        push_seq(8'h3C, 8);
        accept(8'h3C, 0);
        shift_len(n);
        chk("byte 3C shift cycles", n, 32);
        push_seq(8'hFF, 8);
        push_seq(8'h00, 8);
        push_seq(8'h00, 2);
        exp_evt.push_back(4'b1000);
        accept(8'hFF, 1);
        init_done = 1;
        n = 0;
        while (!done && n < 2000) begin tick(); n++; end
        repeat (3) tick();
        chk("nominal done", done, 1);
        chk("nominal busy", busy, 0);
        chk("nominal dclk rises", rise_cnt - base, 34);
        chk("nominal warmres pulses", warm_cnt, 1);

        // nSTATUS never rises
        conf_done = 0;
        init_done = 0;
        status_n = 0;
        base = rise_cnt;
        exp_evt.push_back(4'd1);
        pulse_start();
        chk("done cleared on restart", done, 0);
        wait_ncfg(n);
        wait_err(5000, n);
        chk("nSTATUS timeout cycles", n, 4096);
        chk("no dclk during WSTAT", rise_cnt - base, 0);

        // nSTATUS drops during bit 4 of the second byte
        status_n = 0;
        pulse_start();
        chk("err cleared on restart", {err, err_code}, 0);
        wait_ncfg(n);
        repeat (5) tick();
        status_n = 1;
        push_seq(8'h80, 8);
        accept(8'h01, 0);
        shift_len(n);
        push_seq(8'h30, 4);
        exp_evt.push_back(4'd2);
        accept(8'h3C, 0);
        repeat (16) tick();
        status_n = 0;
        wait_err(20, n);
        chk("nSTATUS-low reaction within 3", n >= 1 && n <= 3, 1);
        chk("nSTATUS-low dclk", dclk, 0);
        chk("nSTATUS-low din_ready", din_ready, 0);

        // last byte with CONF_DONE missing
        conf_done = 0;
        boot_to_load();
        base = rise_cnt;
        wc = warm_cnt;
        push_seq(8'h40, 8);
        exp_evt.push_back(4'd3);
        accept(8'h02, 1);
        wait_err(500, n);
        repeat (5) tick();
        chk("no CONF_DONE err", err, 1);
        chk("no CONF_DONE dclk rises", rise_cnt - base, 8);
        chk("no CONF_DONE warmres", warm_cnt - wc, 0);

        // INIT_DONE stuck low
        boot_to_load();
        conf_done = 1;
        base = rise_cnt;
        push_seq(8'hFF, 8);
        push_seq(8'h00, 8);
        push_seq(8'h00, 2);
        exp_evt.push_back(4'd4);
        accept(8'hFF, 1);
        n = 0;
        while (rise_cnt != base + 18 && n < 500) begin tick(); n++; end
        n = 0;
        while (dclk && n < 10) begin tick(); n++; end
        wait_err(5000, n);
        chk("INIT_DONE timeout cycles", n, 4096);
        status_n = 0;
        pulse_start();
        chk("restart clears err", {err, err_code}, 0);
        chk("restart pulses nCONFIG", config_n, 0);

        // abort in the middle of a byte
        wait_ncfg(n);
        repeat (5) tick();
        status_n = 1;
        push_seq(8'h80, 1);
        accept(8'h01, 0);
        repeat (5) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort config_n", config_n, 1);
        chk("abort dclk", dclk, 0);
        chk("abort busy", busy, 0);
        start = 1;
        abort = 1;
        tick();
        start = 0;
        abort = 0;
        chk("start+abort busy", busy, 0);
        chk("start+abort config_n", config_n, 1);
        repeat (5) tick();
        chk("bit queue drained", exp_bits.size(), 0);
        chk("event queue drained", exp_evt.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
